// File: rtl/serial_chunk_adder.sv
// Wide adder that walks W-bit operands N bits per clock, LSB chunk first, through a registered carry.
// Optional borrow/subtract mode under macro SERIAL_CHUNK_ADDER_SUB_EN (adds input SUB).
module serial_chunk_adder #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         C_IN,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic         SUB,
`endif
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] SUM,
  output logic         C_OUT,
  output logic         BUSY
);

  localparam int K  = W / N;
  localparam int CW = $clog2(K) + 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  ar_q, ar_d;
  logic [W-1:0]  br_q, br_d;
  logic          cr_q, cr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  logic          sub_q, sub_d;
`endif

  logic [N-1:0]   chunk_s;
  logic           chunk_co;
  logic [W+N-1:0] sum_ext;

  // N-bit ripple chain on the low chunk of the shift registers.
  always_comb begin : ripple
    logic c;
    c       = cr_q;
    chunk_s = '0;
    for (int i = 0; i < N; i++) begin
      chunk_s[i] = ar_q[i] ^ br_q[i] ^ c;
      c          = (ar_q[i] & br_q[i]) | (c & (ar_q[i] ^ br_q[i]));
    end
    chunk_co = c;
  end

  // New chunk enters at the top; works unchanged when K == 1.
  assign sum_ext = {chunk_s, sum_q};

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    br_d    = br_q;
    cr_d    = cr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          ar_d    = A;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
          br_d    = SUB ? ~B : B;
          cr_d    = C_IN ^ SUB;
          sub_d   = SUB;
`else
          br_d    = B;
          cr_d    = C_IN;
`endif
        end
      end
      S_RUN: begin
        ar_d  = ar_q >> N;
        br_d  = br_q >> N;
        sum_d = sum_ext[W+N-1:N];
        cr_d  = chunk_co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
          cout_d  = chunk_co ^ sub_q;
`else
          cout_d  = chunk_co;
`endif
        end
      end
      S_DONE: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ar_q    <= '0;
      br_q    <= '0;
      cr_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      cr_q    <= cr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign BUSY      = (state_q != S_IDLE);
  assign SUM       = sum_q;
  assign C_OUT     = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed and randomised checks of serial_chunk_adder at W=32/N=8 and W=8/N=8 (K=1).
module tb_serial_chunk_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic        c_in;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  logic        sub;
`endif
  logic        in_ready, out_valid, c_out, busy;
  logic [31:0] sum;

  logic        in_valid8, out_ready8;
  logic        in_ready8, out_valid8, c_out8, busy8;
  logic [7:0]  sum8;

  int checks = 0;
  int failures = 0;

  serial_chunk_adder #(.W(32), .N(8)) u_dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .C_IN(c_in),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .SUB(sub),
`endif
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .SUM(sum), .C_OUT(c_out), .BUSY(busy)
  );

  serial_chunk_adder #(.W(8), .N(8)) u_dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .A(a[7:0]), .B(b[7:0]), .C_IN(c_in),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .SUB(sub),
`endif
    .OUT_VALID(out_valid8), .OUT_READY(out_ready8),
    .SUM(sum8), .C_OUT(c_out8), .BUSY(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on either instance; expected values come from the caller.
  task automatic run_op(input bit use8, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tc, input logic ts, input int stall, input int exp_lat,
                        input logic [31:0] esum, input logic ecout, input bit hold_valid);
    int n;
    n = 0;
    while (!(use8 ? in_ready8 : in_ready) && n < 40) begin
      step();
      n++;
    end
    chk("idle_in_ready", use8 ? in_ready8 : in_ready, 1'b1);
    a = ta; b = tb_v; c_in = tc;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    sub = ts;
`endif
    if (use8) in_valid8 = 1'b1; else in_valid = 1'b1;
    step();
    if (!hold_valid) begin
      in_valid  = 1'b0;
      in_valid8 = 1'b0;
    end
    a = ~ta; b = ~tb_v; c_in = ~tc;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    sub = ~ts;
`else
    if (ts) chk("sub_requested_without_feature", 1'b1, 1'b0);
`endif
    n = 1;
    while (!(use8 ? out_valid8 : out_valid) && n < 40) begin
      if (hold_valid) begin
        chk("in_ready_low_run", in_ready, 1'b0);
        chk("busy_run", busy, 1'b1);
      end
      step();
      n++;
    end
    chk("latency", n, exp_lat);
    chk("sum", use8 ? {24'h0, sum8} : sum, esum);
    chk("c_out", use8 ? c_out8 : c_out, ecout);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", use8 ? out_valid8 : out_valid, 1'b1);
      chk("stall_sum", use8 ? {24'h0, sum8} : sum, esum);
      chk("stall_c_out", use8 ? c_out8 : c_out, ecout);
      if (hold_valid) chk("in_ready_low_done", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    if (use8) out_ready8 = 1'b1; else out_ready = 1'b1;
    step();
    out_ready  = 1'b0;
    out_ready8 = 1'b0;
    chk("release_valid", use8 ? out_valid8 : out_valid, 1'b0);
    chk("release_in_ready", use8 ? in_ready8 : in_ready, 1'b1);
  endtask

  initial begin
    logic [32:0] model;
    logic [8:0]  model8;
    logic [31:0] ra, rb;
    logic        rc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    sub = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_c_out", c_out, 1'b0);
    step();
    chk("post_rst_in_ready", in_ready, 1'b1);

    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 5, 32'h0000_0000, 1'b1, 0);
    // IN_VALID held high across RUN/DONE with operands changing underneath.
    run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1, 5, 32'hACF1_3569, 1'b0, 1);
    chk("idle_hold_sum", sum, 32'hACF1_3569);
    run_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 3, 5, 32'h0001_0000, 1'b0, 0);

    // Reset in the second RUN cycle aborts the operation.
    a = 32'hDEAD_BEEF; b = 32'h1111_1111; c_in = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_sum", sum, 32'h0);
    chk("abort_c_out", c_out, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_valid", out_valid, 1'b0);
    end
    run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0, 5, 32'd7, 1'b0, 0);

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    run_op(0, 32'd5, 32'd7, 1'b0, 1'b1, 0, 5, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(0, 32'd7, 32'd5, 1'b0, 1'b1, 0, 5, 32'd2, 1'b0, 0);
    run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0, 5, 32'd7, 1'b0, 0);
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      run_op(0, ra, rb, rc, 1'b0, $urandom_range(0, 3), 5, model[31:0], model[32], 0);
    end

    run_op(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 2, 32'h0000_0000, 1'b1, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      model8 = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'h0, rc};
      run_op(1, ra, rb, rc, 1'b0, $urandom_range(0, 3), 2, {24'h0, model8[7:0]}, model8[8], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
